// File: rtl/sp_ram_mp.sv
// Multi-port single-bank RAM: round-robin arbitration of N_PORTS requesters onto
// one word-addressed memory, with byte enables and a fixed one-cycle response.
module sp_ram_mp #(
  parameter int                    N_PORTS    = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_PORTS-1:0]              req_i,
  input  logic [N_PORTS-1:0]              we_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [N_PORTS-1:0]              gnt_o,
  output logic [N_PORTS-1:0]              rvalid_o,
  output logic [N_PORTS-1:0]              err_o,
  output logic [N_PORTS*DATA_WIDTH-1:0]   rdata_o
);

  localparam int          BE_W      = DATA_WIDTH / 8;
  localparam int          OFF_W     = $clog2(BE_W);
  localparam int          IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int          PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(NUM_WORDS) * 64'(BE_W);

  // Handshake: a requester holds req/we/addr/be/wdata until it sees gnt in the
  // same cycle; exactly one cycle later rvalid pulses with err/rdata for it.
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      sel;
  logic                  any_gnt;
  logic [N_PORTS-1:0]    rvalid_q, rvalid_d;
  logic [N_PORTS-1:0]    err_q, err_d;
  logic [N_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  logic [ADDR_WIDTH-1:0] addr_s, off_s;
  logic [BE_W-1:0]       be_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  we_s;
  logic                  in_range;
  logic [IDX_W-1:0]      idx_s;
  logic                  unused_off;

  always_comb begin
    int               j;
    logic [PTR_W-1:0] jj;
    gnt_o   = '0;
    sel     = '0;
    any_gnt = 1'b0;
    j       = 0;
    jj      = '0;
    if (!rst_i) begin
      for (int i = 0; i < N_PORTS; i++) begin
        j = int'(ptr_q) + i;
        if (j >= N_PORTS) j = j - N_PORTS;
        jj = PTR_W'(j);
        if (!any_gnt && req_i[jj]) begin
          any_gnt   = 1'b1;
          sel       = jj;
          gnt_o[jj] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) ptr_d = (sel == PTR_W'(N_PORTS - 1)) ? '0 : sel + 1'b1;
  end

  assign addr_s  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign be_s    = be_i[sel*BE_W +: BE_W];
  assign wdata_s = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign we_s    = we_i[sel];
  assign off_s   = addr_s - BASE_ADDR;
  // The lower-bound test rejects addresses below BASE whose offset wrapped.
  assign in_range   = (addr_s >= BASE_ADDR) && (64'(off_s) < MEM_BYTES);
  assign idx_s      = off_s[OFF_W +: IDX_W];
  assign unused_off = ^off_s;

  always_ff @(posedge clk_i) begin
    if (any_gnt && we_s && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_s[b]) mem_q[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rvalid_d = gnt_o;
    err_d    = '0;
    rdata_d  = '0;
    if (any_gnt && !in_range) err_d[sel] = 1'b1;
    if (any_gnt && in_range && !we_s) rdata_d[sel*DATA_WIDTH +: DATA_WIDTH] = mem_q[idx_s];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_sp_ram_mp.sv
// Bench for sp_ram_mp (4 ports, 256 x 32-bit words at base 0): directed steps
// followed by randomized traffic, all checked against a queue-free array model.
module tb_sp_ram_mp;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 256;
  localparam logic [AW-1:0] BASE = '0;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [NP-1:0]      req_i = '0;
  logic [NP-1:0]      we_i = '0;
  logic [NP*AW-1:0]   addr_i = '0;
  logic [NP*DW/8-1:0] be_i = '0;
  logic [NP*DW-1:0]   wdata_i = '0;
  logic [NP-1:0]      gnt_o;
  logic [NP-1:0]      rvalid_o;
  logic [NP-1:0]      err_o;
  logic [NP*DW-1:0]   rdata_o;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0]    mem_m [NW];
  int               ptr_m = 0;
  logic [NP-1:0]    exp_rv = '0, exp_err = '0, last_gnt = '0;
  logic [NP*DW-1:0] exp_rd = '0;
  bit               pend [NP];

  sp_ram_mp #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .be_i(be_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_port(int k, bit r, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    req_i[k] = r;
    we_i[k] = w;
    addr_i[k*AW +: AW] = a;
    be_i[k*4 +: 4] = b;
    wdata_i[k*DW +: DW] = d;
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic cycle();
    logic [NP-1:0]    eg, nrv, nerr;
    logic [NP*DW-1:0] nrd;
    logic [31:0]      a;
    longint           off;
    int               k, idx;
    bit               found;
    @(negedge clk_i);
    eg = '0; found = 0; k = 0;
    for (int i = 0; i < NP; i++) begin
      if (!found && req_i[(ptr_m + i) % NP]) begin
        found = 1;
        k = (ptr_m + i) % NP;
        eg[k] = 1'b1;
      end
    end
    check("gnt", 128'(gnt_o), 128'(eg));
    check("rvalid", 128'(rvalid_o), 128'(exp_rv));
    check("err", 128'(err_o & rvalid_o), 128'(exp_err));
    check("rdata", 128'(rdata_o), 128'(exp_rd));
    nrv = '0; nerr = '0; nrd = '0;
    if (found) begin
      a = addr_i[k*AW +: AW];
      off = longint'(a) - longint'(BASE);
      nrv[k] = 1'b1;
      if (off < 0 || off >= NW * 4) nerr[k] = 1'b1;
      else begin
        idx = int'(off / 4);
        if (we_i[k]) begin
          for (int b = 0; b < 4; b++)
            if (be_i[k*4 + b]) mem_m[idx][b*8 +: 8] = wdata_i[k*DW + b*8 +: 8];
        end else begin
          nrd[k*DW +: DW] = mem_m[idx];
        end
      end
      ptr_m = (k + 1) % NP;
    end
    last_gnt = eg;
    @(posedge clk_i);
    #1;
    exp_rv = nrv; exp_err = nerr; exp_rd = nrd;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    exp_rv = '0; exp_err = '0; exp_rd = '0; ptr_m = 0;
    @(negedge clk_i);
    check("rst_gnt", 128'(gnt_o), 128'(0));
    check("rst_rvalid", 128'(rvalid_o), 128'(0));
    check("rst_err", 128'(err_o), 128'(0));
    check("rst_rdata", 128'(rdata_o), 128'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NP; k++) set_port(k, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70)      return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
    else if (r < 85) return 32'($urandom_range(0, NW - 1) * 4);
    else if (r < 93) return 32'h400 + 32'($urandom_range(0, 255));
    else             return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
  endfunction

  initial begin
    do_reset();

    for (int w = 0; w < NW; w++) begin
      set_port(0, 1, 1, 32'(w * 4), 4'hF, $urandom);
      cycle();
    end
    clear_all();
    cycle();

    // Write then immediately read the same word.
    set_port(0, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    cycle();
    set_port(0, 1, 0, 32'h10, 4'h0, 32'h0);
    cycle();
    check("r036_rvalid", 128'(rvalid_o[0]), 128'(1));
    check("r036_err", 128'(err_o[0]), 128'(0));
    check("r036_rdata", 128'(rdata_o[31:0]), 128'(32'hDEADBEEF));
    clear_all();
    cycle();

    set_port(0, 1, 1, 32'h8, 4'hF, 32'h11223344);
    cycle();
    set_port(0, 1, 1, 32'h8, 4'b0101, 32'hAABBCCDD);
    cycle();
    set_port(0, 1, 0, 32'h8, 4'h0, 32'h0);
    cycle();
    check("r038_rdata", 128'(rdata_o[31:0]), 128'(32'h11BB33DD));

    set_port(0, 1, 0, 32'h400, 4'hF, 32'h0);
    cycle();
    check("r039_oor_rvalid", 128'(rvalid_o[0]), 128'(1));
    check("r039_oor_err", 128'(err_o[0]), 128'(1));
    check("r039_oor_rdata", 128'(rdata_o[31:0]), 128'(0));
    set_port(0, 1, 0, 32'h3FC, 4'hF, 32'h0);
    cycle();
    check("r039_last_err", 128'(err_o[0]), 128'(0));
    clear_all();
    cycle();

    // Reset in the response cycle cancels it and returns the pointer to 0.
    set_port(1, 1, 0, 32'h20, 4'hF, 32'h0);
    cycle();
    clear_all();
    set_port(0, 1, 0, 32'h24, 4'hF, 32'h0);
    set_port(2, 1, 0, 32'h28, 4'hF, 32'h0);
    do_reset();
    cycle();
    check("r040_first_gnt", 128'(rvalid_o), 128'(4'b0001));
    clear_all();
    cycle();

    do_reset();
    set_port(0, 1, 0, 32'h0, 4'hF, 32'h0);
    set_port(1, 1, 0, 32'h4, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("r037_rv", 128'(rvalid_o), 128'((i % 2 == 0) ? 4'b0001 : 4'b0010));
    end
    clear_all();
    cycle();

    // Pointer is now 2: port 3 must win over port 1.
    set_port(1, 1, 0, 32'h30, 4'hF, 32'h0);
    set_port(3, 1, 0, 32'h34, 4'hF, 32'h0);
    cycle();
    check("r041_first", 128'(rvalid_o), 128'(4'b1000));
    set_port(3, 0, 0, 32'h0, 4'h0, 32'h0);
    cycle();
    check("r041_second", 128'(rvalid_o), 128'(4'b0010));
    clear_all();
    cycle();

    for (int k = 0; k < NP; k++) pend[k] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NP; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 50) begin
          set_port(k, 1, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom_range(0, 15)), $urandom);
          pend[k] = 1;
        end
      end
      cycle();
      for (int k = 0; k < NP; k++) begin
        if (last_gnt[k]) begin
          pend[k] = 0;
          set_port(k, 0, 0, 0, 0, 0);
        end
      end
    end
    clear_all();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
